// File: rtl/array_arb_pkg.sv
// Shared types, constants and init-value helper for the arbitrated register array.
package array_arb_pkg;

   localparam int unsigned NUM_REQ = 2;

   typedef enum logic {
      S_INIT = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   // Power-up contents of entry i: odd numbers 1, 3, 5, ...
   function automatic int unsigned init_val(input int unsigned i);
      return 32'(2 * i + 1);
   endfunction

endpackage

// File: rtl/array_port_arbiter_if.sv
// Request/response bus between the requesters and the shared array.
interface array_port_arbiter_if
   import array_arb_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 2
);
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_write;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*DATA_W-1:0] req_wdata;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ-1:0]        rsp_valid;
   logic [DATA_W-1:0]         rsp_rdata;
   logic                      init_done;

   modport master (
      output req_valid, req_write, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, init_done
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, init_done
   );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; pointer names the requester favoured on a tie.
module rr_arbiter2
   import array_arb_pkg::*;
(
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic [NUM_REQ-1:0] i_req,
   output logic [NUM_REQ-1:0] o_gnt_c
);

   logic r_ptr;

   // One-hot grant: pointer breaks a tie, a lone request always wins
   always_comb begin
      o_gnt_c = '0;
      if (i_req == 2'b11) begin
         o_gnt_c = r_ptr ? 2'b10 : 2'b01;
      end else begin
         o_gnt_c = i_req;
      end
   end

   // After a grant, favour the requester that lost; hold when idle
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_ptr <= 1'b0;
      end else if (|o_gnt_c) begin
         r_ptr <= ~o_gnt_c[1];
      end
   end

endmodule

// File: rtl/array_port_arbiter.sv
// Shared DEPTH-entry register array with power-up fill and round-robin access.
module array_port_arbiter
   import array_arb_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned ADDR_W = 2
)(
   input  logic clk,
   input  logic reset,
   array_port_arbiter_if.slave bus
);

   localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

   logic [DATA_W-1:0]  r_arr [DEPTH];
   state_t             r_state;
   logic [ADDR_W-1:0]  r_cnt;
   logic [NUM_REQ-1:0] r_rsp_valid;
   logic [DATA_W-1:0]  r_rsp_rdata;
   logic               r_init_done;

   logic [NUM_REQ-1:0] w_req;
   logic [NUM_REQ-1:0] w_gnt;
   logic               w_gidx;
   logic               w_write;
   logic [ADDR_W-1:0]  w_addr;
   logic [DATA_W-1:0]  w_wdata;
   logic               w_in_range;

   // Requests are only visible to the arbiter once the fill has finished
   assign w_req = bus.req_valid & {NUM_REQ{r_state == S_RUN}};

   rr_arbiter2 u_arb (
      .i_clk   (clk),
      .i_reset (reset),
      .i_req   (w_req),
      .o_gnt_c (w_gnt)
   );

   // Select the granted requester's command
   assign w_gidx     = w_gnt[1];
   assign w_write    = w_gidx ? bus.req_write[1] : bus.req_write[0];
   assign w_addr     = w_gidx ? bus.req_addr[2*ADDR_W-1:ADDR_W] : bus.req_addr[ADDR_W-1:0];
   assign w_wdata    = w_gidx ? bus.req_wdata[2*DATA_W-1:DATA_W] : bus.req_wdata[DATA_W-1:0];
   assign w_in_range = ({1'b0, w_addr} < DEPTH_X);

   // Array storage: fill sequence, then granted in-range writes
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (r_state == S_INIT) begin
            r_arr[r_cnt] <= DATA_W'(init_val(32'(r_cnt)));
         end else if ((|w_gnt) && w_write && w_in_range) begin
            r_arr[w_addr] <= w_wdata;
         end
      end
   end

   // Control FSM and one-cycle read response register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_INIT;
         r_cnt       <= '0;
         r_rsp_valid <= '0;
         r_rsp_rdata <= '0;
         r_init_done <= 1'b0;
      end else begin
         r_rsp_valid <= '0;
         r_rsp_rdata <= '0;
         case (r_state)
            S_INIT: begin
               if (r_cnt == LAST_IDX) begin
                  r_state     <= S_RUN;
                  r_init_done <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + ADDR_W'(1);
               end
            end
            S_RUN: begin
               if ((|w_gnt) && !w_write) begin
                  r_rsp_valid <= w_gnt;
                  r_rsp_rdata <= w_in_range ? r_arr[w_addr] : '0;
               end
            end
            default: r_state <= S_INIT;
         endcase
      end
   end

   assign bus.req_ready = w_gnt;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_rdata = r_rsp_rdata;
   assign bus.init_done = r_init_done;

endmodule

// File: tb/tb_array_port_arbiter.sv
// Scoreboard bench: a DEPTH=4 and a DEPTH=3 instance receive identical traffic.
module tb_array_port_arbiter;

   typedef struct {
      logic [1:0]  v;
      logic [31:0] d;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  req_valid = '0;
   logic [1:0]  req_write = '0;
   logic [3:0]  req_addr  = '0;
   logic [63:0] req_wdata = '0;
   logic        mon_en = 1'b0;

   int n_cmp = 0;
   int n_err = 0;
   exp_t q4[$];
   exp_t q3[$];

   always #5 clk = ~clk;

   array_port_arbiter_if #(.DATA_W(32), .ADDR_W(2)) bus4 ();
   array_port_arbiter_if #(.DATA_W(32), .ADDR_W(2)) bus3 ();

   assign bus4.req_valid = req_valid;
   assign bus4.req_write = req_write;
   assign bus4.req_addr  = req_addr;
   assign bus4.req_wdata = req_wdata;
   assign bus3.req_valid = req_valid;
   assign bus3.req_write = req_write;
   assign bus3.req_addr  = req_addr;
   assign bus3.req_wdata = req_wdata;

   array_port_arbiter #(.DATA_W(32), .DEPTH(4), .ADDR_W(2)) u_dut4 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus4.slave)
   );

   array_port_arbiter #(.DATA_W(32), .DEPTH(3), .ADDR_W(2)) u_dut3 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus3.slave)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor for the DEPTH=4 instance
   always @(negedge clk) begin
      if (mon_en) begin
         if (bus4.rsp_valid != 2'b00) begin
            if (q4.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL rsp4_unexpected: got valid 0x%0h data 0x%0h expected no response",
                        bus4.rsp_valid, bus4.rsp_rdata);
            end else begin
               exp_t e;
               e = q4.pop_front();
               chk("rsp4_valid", 64'(bus4.rsp_valid), 64'(e.v));
               chk("rsp4_rdata", 64'(bus4.rsp_rdata), 64'(e.d));
            end
         end else begin
            chk("rsp4_idle_rdata", 64'(bus4.rsp_rdata), 64'd0);
         end
      end
   end

   // Monitor for the DEPTH=3 instance
   always @(negedge clk) begin
      if (mon_en) begin
         if (bus3.rsp_valid != 2'b00) begin
            if (q3.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL rsp3_unexpected: got valid 0x%0h data 0x%0h expected no response",
                        bus3.rsp_valid, bus3.rsp_rdata);
            end else begin
               exp_t e;
               e = q3.pop_front();
               chk("rsp3_valid", 64'(bus3.rsp_valid), 64'(e.v));
               chk("rsp3_rdata", 64'(bus3.rsp_rdata), 64'(e.d));
            end
         end else begin
            chk("rsp3_idle_rdata", 64'(bus3.rsp_rdata), 64'd0);
         end
      end
   end

   // One request cycle: drive, check grant, queue expected read data per instance
   task automatic step(input logic [1:0] v, input logic [1:0] w,
                       input logic [1:0] a0, input logic [1:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic [1:0] eg, input logic [31:0] e4, input logic [31:0] e3);
      @(negedge clk);
      req_valid = v;
      req_write = w;
      req_addr  = {a1, a0};
      req_wdata = {d1, d0};
      #1;
      chk("ready4", 64'(bus4.req_ready), 64'(eg));
      chk("ready3", 64'(bus3.req_ready), 64'(eg));
      if ((eg[0] && !w[0]) || (eg[1] && !w[1])) begin
         q4.push_back(exp_t'{eg, e4});
         q3.push_back(exp_t'{eg, e3});
      end
   endtask

   // Four cycles after reset release: fill timing of both instances
   task automatic init_check();
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         chk("init_done4", 64'(bus4.init_done), 64'(k >= 4));
         chk("init_done3", 64'(bus3.init_done), 64'(k >= 3));
         chk("init_ready4", 64'(bus4.req_ready), 64'd0);
         chk("init_ready3", 64'(bus3.req_ready), 64'd0);
      end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      mon_en = 1'b1;
      reset  = 1'b0;
      init_check();

      // Fill contents via requester 0
      step(2'b01, 2'b00, 2'd0, 2'd0, 0, 0, 2'b01, 32'd1, 32'd1);
      step(2'b01, 2'b00, 2'd1, 2'd0, 0, 0, 2'b01, 32'd3, 32'd3);
      step(2'b01, 2'b00, 2'd2, 2'd0, 0, 0, 2'b01, 32'd5, 32'd5);
      step(2'b01, 2'b00, 2'd3, 2'd0, 0, 0, 2'b01, 32'd7, 32'd0);
      // Lone requester 1 moves the pointer back to 0
      step(2'b10, 2'b00, 2'd0, 2'd0, 0, 0, 2'b10, 32'd1, 32'd1);

      // Round robin with both reading
      step(2'b11, 2'b00, 2'd1, 2'd2, 0, 0, 2'b01, 32'd3, 32'd3);
      step(2'b11, 2'b00, 2'd1, 2'd2, 0, 0, 2'b10, 32'd5, 32'd5);
      step(2'b11, 2'b00, 2'd1, 2'd2, 0, 0, 2'b01, 32'd3, 32'd3);
      step(2'b11, 2'b00, 2'd1, 2'd2, 0, 0, 2'b10, 32'd5, 32'd5);

      // Write by requester 1, read back by requester 0 next cycle
      step(2'b10, 2'b10, 2'd0, 2'd3, 0, 32'hDEADBEEF, 2'b10, 0, 0);
      step(2'b01, 2'b00, 2'd3, 2'd0, 0, 0, 2'b01, 32'hDEADBEEF, 32'd0);

      // Address 3 is out of range for the DEPTH=3 instance
      step(2'b01, 2'b01, 2'd3, 2'd0, 32'h55, 0, 2'b01, 0, 0);
      step(2'b10, 2'b00, 2'd0, 2'd3, 0, 0, 2'b10, 32'h55, 32'd0);
      step(2'b01, 2'b00, 2'd0, 2'd0, 0, 0, 2'b01, 32'd1, 32'd1);
      step(2'b01, 2'b00, 2'd1, 2'd0, 0, 0, 2'b01, 32'd3, 32'd3);
      step(2'b01, 2'b00, 2'd2, 2'd0, 0, 0, 2'b01, 32'd5, 32'd5);

      // Requester 1 alone, every cycle
      step(2'b10, 2'b00, 2'd0, 2'd2, 0, 0, 2'b10, 32'd5, 32'd5);
      step(2'b10, 2'b00, 2'd0, 2'd1, 0, 0, 2'b10, 32'd3, 32'd3);
      step(2'b10, 2'b00, 2'd0, 2'd0, 0, 0, 2'b10, 32'd1, 32'd1);

      // Idle cycle, then a write/read tie on address 0
      step(2'b00, 2'b00, 2'd0, 2'd0, 0, 0, 2'b00, 0, 0);
      step(2'b11, 2'b01, 2'd0, 2'd0, 32'h1234, 0, 2'b01, 0, 0);
      step(2'b10, 2'b00, 2'd0, 2'd0, 0, 0, 2'b10, 32'h1234, 32'h1234);

      // Reset on the edge that would complete a granted read
      @(negedge clk);
      req_valid = 2'b01;
      req_write = 2'b00;
      req_addr  = 4'd0;
      reset     = 1'b1;
      #1;
      chk("midop_ready4", 64'(bus4.req_ready), 64'h1);
      chk("midop_ready3", 64'(bus3.req_ready), 64'h1);
      @(negedge clk);
      req_valid = 2'b00;
      chk("midop_rsp4", 64'(bus4.rsp_valid), 64'd0);
      chk("midop_rsp3", 64'(bus3.rsp_valid), 64'd0);
      chk("midop_init4", 64'(bus4.init_done), 64'd0);
      chk("midop_init3", 64'(bus3.init_done), 64'd0);
      reset = 1'b0;
      init_check();

      // Refill overwrote the earlier 0x1234
      step(2'b01, 2'b00, 2'd0, 2'd0, 0, 0, 2'b01, 32'd1, 32'd1);
      step(2'b00, 2'b00, 2'd0, 2'd0, 0, 0, 2'b00, 0, 0);
      step(2'b00, 2'b00, 2'd0, 2'd0, 0, 0, 2'b00, 0, 0);

      chk("q4_drained", 64'(q4.size()), 64'd0);
      chk("q3_drained", 64'(q3.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
